div_32bit_seq: RTL



---
 rtl/div_32bit_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/div_32bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results and div_by_zero hold until the next accepted start.
module div_32bit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step; trial[WIDTH] set means the subtraction went negative.
  always_comb begin
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor};
    rem_next  = rem_shift;
    quo_next  = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (value2 == '0) begin
              state       <= StDone;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= value1;
              div_by_zero <= 1'b1;
            end else begin
              state       <= StCalc;
              quo         <= value1;
              divisor     <= value2;
              rem         <= '0;
              div_by_zero <= 1'b0;
              count       <= '0;
            end
          end
        end
        StCalc: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
          // Outputs only change once the last quotient bit is known.
          if (count == LastCount) begin
            state     <= StDone;
            done      <= 1'b1;
            quotient  <= quo_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
